// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Sequential instruction-fetch stage. Holds the PC, issues one read per
//   instruction to a word-addressed instruction memory, waits for the response
//   and presents the captured word to decode with a valid/ready handshake,
//   together with its PC and a registered opcode-class tag. Redirects from
//   downstream reload the PC and discard any stale in-flight response; a
//   misaligned redirect target raises a sticky fault and halts the stage.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   mem_addr/mem_read fetch request; mem_addr always equals pc
//   mem_rdata/rvalid  memory response (may arrive in the request cycle)
//   instr, instr_pc   captured instruction word and the PC it came from
//   instr_type        0=unknown 1=R 2=I 3=S 4=SB 5=UJ, registered at capture
//   instr_valid       instr/instr_pc/instr_type valid for decode
//   instr_ready       decode accepts this cycle
//   redirect(_pc)     load a new PC and flush the current instruction
//   fault             sticky misaligned-redirect flag
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h28)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [2:0]        instr_type,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              fault
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,  // request outstanding at pc
    S_VALID = 2'd1,  // instruction held for decode
    S_DRAIN = 2'd2,  // waiting out the response of a cancelled request
    S_HALT  = 2'd3   // misaligned redirect seen; only reset leaves
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       instr_q;
  logic [ADDR_W-1:0] instr_pc_q;
  logic [2:0]        instr_type_q;
  logic              fault_q;

  // Opcode class of a RISC-V instruction word, from bits [6:0].
  function automatic logic [2:0] classify(input logic [6:0] opcode);
    logic [2:0] cls;
    cls = 3'd0;
    case (opcode)
      7'h33:        cls = 3'd1;
      7'h03, 7'h13: cls = 3'd2;
      7'h23:        cls = 3'd3;
      7'h63:        cls = 3'd4;
      7'h6f:        cls = 3'd5;
      default:      cls = 3'd0;
    endcase
    return cls;
  endfunction

  // NOTE: every register below is written with non-blocking assignments so
  // all of them update together at the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      instr_pc_q   <= '0;
      instr_type_q <= '0;
      fault_q      <= 1'b0;
    end else if (state_q != S_HALT && redirect) begin
      // Redirect outranks every other event; HALT ignores it entirely.
      if (redirect_pc[1:0] != 2'b00) begin
        fault_q <= 1'b1;
        state_q <= S_HALT;
      end else begin
        pc_q <= redirect_pc;
        // A request still in flight must have its response drained; a
        // response arriving this very cycle is simply dropped.
        if (state_q == S_DRAIN || (state_q == S_FETCH && !mem_rvalid)) begin
          state_q <= S_DRAIN;
        end else begin
          state_q <= S_FETCH;
        end
      end
    end else begin
      case (state_q)
        S_FETCH: begin
          if (mem_rvalid) begin
            instr_q      <= mem_rdata;
            instr_pc_q   <= pc_q;
            // The class is captured with the word so it never tracks a
            // later value on the memory bus.
            instr_type_q <= classify(mem_rdata[6:0]);
            pc_q         <= pc_q + ADDR_W'(4);
            state_q      <= S_VALID;
          end
        end
        S_VALID: begin
          if (instr_ready) begin
            state_q <= S_FETCH;
          end
        end
        S_DRAIN: begin
          if (mem_rvalid) begin
            state_q <= S_FETCH;
          end
        end
        default: begin
          state_q <= S_HALT;
        end
      endcase
    end
  end

  // Outputs decode directly from registered state, so they are glitch-free
  // and fall asynchronously with reset.
  assign mem_addr    = pc_q;
  assign mem_read    = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign instr_valid = (state_q == S_VALID);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_type  = instr_type_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Directed bench for instr_fetch_unit. A small word memory answers either
//   with zero wait (rvalid = mem_read) or under manual control for latency and
//   stale-response scenarios. Outputs are sampled 2 time units after the
//   rising edge; inputs are changed at the same point.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [2:0]  instr_type;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fault;

  // Memory model: zero-wait mode or manually driven response.
  logic [31:0] mem [0:127];
  logic        zw;
  logic        rv_man;
  logic [31:0] rd_man;

  assign mem_rdata  = zw ? mem[mem_addr[8:2]] : rd_man;
  assign mem_rvalid = zw ? mem_read : rv_man;

  instr_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_addr    (mem_addr),
    .mem_read    (mem_read),
    .mem_rdata   (mem_rdata),
    .mem_rvalid  (mem_rvalid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_type  (instr_type),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Expected program 0x28..0x50 and its opcode classes.
  logic [31:0] prog  [11];
  logic [2:0]  ptype [11];

  initial begin
    prog[0]  = 32'h00a00093; ptype[0]  = 3'd2;
    prog[1]  = 32'h002081b3; ptype[1]  = 3'd1;
    prog[2]  = 32'h0000a203; ptype[2]  = 3'd2;
    prog[3]  = 32'h0030a023; ptype[3]  = 3'd3;
    prog[4]  = 32'h00208463; ptype[4]  = 3'd4;
    prog[5]  = 32'h0080006f; ptype[5]  = 3'd5;
    prog[6]  = 32'h0000007f; ptype[6]  = 3'd0;
    prog[7]  = 32'h00000033; ptype[7]  = 3'd1;
    prog[8]  = 32'h00000013; ptype[8]  = 3'd2;
    prog[9]  = 32'h00000023; ptype[9]  = 3'd3;
    prog[10] = 32'h00000063; ptype[10] = 3'd4;
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    for (int i = 0; i < 11; i++) mem[10 + i] = prog[i];
    mem[21] = 32'h00002003;  // 0x54, I-type, used for backpressure
    mem[64] = 32'h0100006f;  // 0x100, UJ-type, redirect target

    rst_n       = 1'b0;
    zw          = 1'b1;
    rv_man      = 1'b0;
    rd_man      = 32'h0;
    instr_ready = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;

    // Reset state.
    #1;
    check("rst_valid", instr_valid, 1'b0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc", instr_pc, 32'h0);
    check("rst_type", instr_type, 3'd0);
    check("rst_fault", fault, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;

    // Sequential stream, zero-wait memory, ready held high.
    for (int i = 0; i < 11; i++) begin
      check($sformatf("seq%0d_addr", i), mem_addr, 32'h28 + 32'(4 * i));
      check($sformatf("seq%0d_read", i), mem_read, 1'b1);
      check($sformatf("seq%0d_nvalid", i), instr_valid, 1'b0);
      tick();
      check($sformatf("seq%0d_valid", i), instr_valid, 1'b1);
      check($sformatf("seq%0d_instr", i), instr, prog[i]);
      check($sformatf("seq%0d_pc", i), instr_pc, 32'h28 + 32'(4 * i));
      check($sformatf("seq%0d_type", i), instr_type, ptype[i]);
      check($sformatf("seq%0d_noread", i), mem_read, 1'b0);
      tick();
    end

    // Backpressure: ready low for 5 VALID cycles at 0x54.
    instr_ready = 1'b0;
    check("bp_addr", mem_addr, 32'h54);
    tick();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d_valid", k), instr_valid, 1'b1);
      check($sformatf("bp%0d_instr", k), instr, 32'h00002003);
      check($sformatf("bp%0d_pc", k), instr_pc, 32'h54);
      check($sformatf("bp%0d_type", k), instr_type, 3'd2);
      check($sformatf("bp%0d_noread", k), mem_read, 1'b0);
      if (k < 4) tick();
    end
    instr_ready = 1'b1;
    tick();
    // One accept only: valid is gone, next request at 0x58, data retained.
    check("bp_accept_valid", instr_valid, 1'b0);
    check("bp_next_addr", mem_addr, 32'h58);
    check("bp_hold_instr", instr, 32'h00002003);

    // 3-cycle latency with redirect to 0x100 in the request's first cycle.
    zw          = 1'b0;
    rv_man      = 1'b0;
    rd_man      = 32'hdead0033;
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    check("drain1_read", mem_read, 1'b1);
    check("drain1_addr", mem_addr, 32'h100);
    check("drain1_valid", instr_valid, 1'b0);
    tick();
    check("drain2_read", mem_read, 1'b1);
    check("drain2_valid", instr_valid, 1'b0);
    rv_man = 1'b1;  // late response to the cancelled 0x58 request
    tick();
    rv_man = 1'b0;
    check("drain_disc_valid", instr_valid, 1'b0);
    check("drain_disc_instr", instr, 32'h00002003);
    check("refetch_addr", mem_addr, 32'h100);
    check("refetch_read", mem_read, 1'b1);
    zw = 1'b1;
    tick();
    check("tgt_valid", instr_valid, 1'b1);
    check("tgt_instr", instr, 32'h0100006f);
    check("tgt_pc", instr_pc, 32'h100);
    check("tgt_type", instr_type, 3'd5);
    tick();
    check("tgt_next_addr", mem_addr, 32'h104);

    // Misaligned redirect, outranking a same-cycle response.
    redirect    = 1'b1;
    redirect_pc = 32'h102;
    tick();
    check("mis_fault", fault, 1'b1);
    check("mis_valid", instr_valid, 1'b0);
    check("mis_read", mem_read, 1'b0);
    check("mis_pc_kept", mem_addr, 32'h104);
    // Aligned redirect in HALT is ignored.
    redirect_pc = 32'h200;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("halt%0d_fault", k), fault, 1'b1);
      check($sformatf("halt%0d_valid", k), instr_valid, 1'b0);
      check($sformatf("halt%0d_read", k), mem_read, 1'b0);
      check($sformatf("halt%0d_addr", k), mem_addr, 32'h104);
    end
    redirect = 1'b0;

    // Reset clears fault and restarts at 0x28.
    rst_n = 1'b0;
    #1;
    check("hrst_fault", fault, 1'b0);
    check("hrst_addr", mem_addr, 32'h28);
    check("hrst_instr", instr, 32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    check("hrel_addr", mem_addr, 32'h28);
    check("hrel_read", mem_read, 1'b1);
    tick();
    check("hrel_valid", instr_valid, 1'b1);
    check("hrel_instr", instr, 32'h00a00093);
    check("hrel_pc", instr_pc, 32'h28);

    // Reset pulsed mid-VALID: valid drops before the next edge.
    instr_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("vrst_valid", instr_valid, 1'b0);
    check("vrst_pc", instr_pc, 32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    check("vrel_addr", mem_addr, 32'h28);
    check("vrel_read", mem_read, 1'b1);
    tick();
    check("vrel_valid", instr_valid, 1'b1);
    check("vrel_pc", instr_pc, 32'h28);
    check("vrel_type", instr_type, 3'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
